// File: rtl/rr_req_queue.sv
// rr_req_queue: four independent request FIFOs feeding a round-robin arbiter.
// Each FIFO's occupancy drives one request line, and the arbiter's one-hot
// grant pops that port's head word into a registered output stage.
module rr_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            push_i,
  input  logic [4*DATA_W-1:0]   push_data_i,
  output logic [3:0]            full_o,
  output logic [3:0]            req_o,
  input  logic [3:0]            gnt_i,
  output logic                  out_valid_o,
  output logic [1:0]            out_port_o,
  output logic [DATA_W-1:0]     out_data_o,
  output logic                  err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem   [4][DEPTH];
  logic [AW-1:0]     wptr  [4];
  logic [AW-1:0]     rptr  [4];
  logic [AW:0]       count [4];

  logic [3:0]        push_acc;
  logic [3:0]        pop_vec;
  logic              gnt_onehot;
  logic              pop_ok;
  logic              proto_err;
  logic [1:0]        pop_idx;
  logic [DATA_W-1:0] head;

  // Request/full flags decode registered counters only, so the arbiter's
  // combinational grant can depend on req_o without forming a loop.
  always_comb begin
    for (int unsigned p = 0; p < 4; p++) begin
      full_o[p] = (count[p] == CNT_FULL);
      req_o[p]  = (count[p] != '0);
    end
  end

  // Grant qualification, push acceptance and protocol-error detection.
  always_comb begin
    gnt_onehot = (gnt_i != '0) && ((gnt_i & (gnt_i - 4'd1)) == '0);
    pop_ok     = gnt_onehot && ((gnt_i & req_o) != '0);
    pop_vec    = pop_ok ? gnt_i : '0;
    push_acc   = push_i & ~full_o;
    proto_err  = ((push_i & full_o) != '0) || ((gnt_i != '0) && !pop_ok);
    pop_idx    = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      if (gnt_i[p]) pop_idx = 2'(p);
    end
  end

  assign head = mem[pop_idx][rptr[pop_idx]];

  // Payload storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 4; p++) begin
      if (push_acc[p]) mem[p][wptr[p]] <= push_data_i[p*DATA_W +: DATA_W];
    end
  end

  // Per-port pointers and occupancy; push and pop in one cycle cancel in count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned p = 0; p < 4; p++) begin
        wptr[p]  <= '0;
        rptr[p]  <= '0;
        count[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 4; p++) begin
        if (push_acc[p]) wptr[p] <= wptr[p] + 1'b1;
        if (pop_vec[p])  rptr[p] <= rptr[p] + 1'b1;
        count[p] <= count[p] + {{AW{1'b0}}, push_acc[p]} - {{AW{1'b0}}, pop_vec[p]};
      end
    end
  end

  // Registered pop output; port/data hold their last values between pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_o <= 1'b0;
      out_port_o  <= '0;
      out_data_o  <= '0;
    end else begin
      out_valid_o <= pop_ok;
      if (pop_ok) begin
        out_port_o <= pop_idx;
        out_data_o <= head;
      end
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_o <= 1'b0;
    else if (proto_err) err_o <= 1'b1;
  end

endmodule

// File: tb/tb_rr_req_queue.sv
// Directed testbench for rr_req_queue: vector table plus hand-written
// reset, invalid-grant and round-robin arbiter sequences.
module tb_rr_req_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  push_i = '0;
  logic [31:0] push_data_i = '0;
  logic [3:0]  full_o, req_o, gnt_i = '0;
  logic        out_valid_o, err_o;
  logic [1:0]  out_port_o;
  logic [7:0]  out_data_o;

  int n_vec  = 0;
  int n_fail = 0;

  rr_req_queue #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .push_i(push_i), .push_data_i(push_data_i),
    .full_o(full_o), .req_o(req_o), .gnt_i(gnt_i), .out_valid_o(out_valid_o),
    .out_port_o(out_port_o), .out_data_o(out_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  push;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  req;
    logic [3:0]  full;
    logic        valid;
    logic [1:0]  port;
    logic [7:0]  dout;
    logic        err;
  } vec_t;

  vec_t tbl [28];

  task automatic check(input string name, input logic [3:0] er, input logic [3:0] ef,
                       input logic ev, input logic [1:0] ep, input logic [7:0] ed,
                       input logic ee);
    logic [19:0] act, want;
    act  = {req_o, full_o, out_valid_o, out_port_o, out_data_o, err_o};
    want = {er, ef, ev, ep, ed, ee};
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got req=%b full=%b v=%b port=%0d data=%h err=%b, want req=%b full=%b v=%b port=%0d data=%h err=%b",
               name, req_o, full_o, out_valid_o, out_port_o, out_data_o, err_o,
               er, ef, ev, ep, ed, ee);
    end
  endtask

  // Drive inputs away from the active edge, then sample just after it.
  task automatic step(input logic [3:0] p, input logic [31:0] d, input logic [3:0] g);
    @(negedge clk);
    push_i = p; push_data_i = d; gnt_i = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_i = 4'($urandom_range(0, 15));
      push_data_i = $urandom;
      gnt_i = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check({name, "_in"}, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
      @(negedge clk);
    end
    reset = 1'b1; push_i = '0; push_data_i = '0; gnt_i = '0;
    @(posedge clk);
    #1;
    check({name, "_out"}, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  initial begin
    // FIFO order on port 2
    tbl[0]  = '{4'b0100, 32'h0011_0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[1]  = '{4'b0100, 32'h0022_0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[2]  = '{4'b0100, 32'h0033_0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    tbl[3]  = '{4'b0000, 32'h0,         4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2, 8'h11, 1'b0};
    tbl[4]  = '{4'b0000, 32'h0,         4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2, 8'h22, 1'b0};
    tbl[5]  = '{4'b0000, 32'h0,         4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 8'h33, 1'b0};
    tbl[6]  = '{4'b0000, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 8'h33, 1'b0};
    // Fill port 0, overflow, push-while-full-with-pop rejected, drain
    tbl[7]  = '{4'b0001, 32'h0000_0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd2, 8'h33, 1'b0};
    tbl[8]  = '{4'b0001, 32'h0000_0002, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd2, 8'h33, 1'b0};
    tbl[9]  = '{4'b0001, 32'h0000_0003, 4'b0000, 4'b0001, 4'b0000, 1'b0, 2'd2, 8'h33, 1'b0};
    tbl[10] = '{4'b0001, 32'h0000_0004, 4'b0000, 4'b0001, 4'b0001, 1'b0, 2'd2, 8'h33, 1'b0};
    tbl[11] = '{4'b0001, 32'h0000_0005, 4'b0000, 4'b0001, 4'b0001, 1'b0, 2'd2, 8'h33, 1'b1};
    tbl[12] = '{4'b0001, 32'h0000_0006, 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h01, 1'b1};
    tbl[13] = '{4'b0000, 32'h0,         4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h02, 1'b1};
    tbl[14] = '{4'b0000, 32'h0,         4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0, 8'h03, 1'b1};
    tbl[15] = '{4'b0000, 32'h0,         4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 8'h04, 1'b1};
    // Simultaneous push/pop on port 1
    tbl[16] = '{4'b0010, 32'h0000_A100, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 8'h04, 1'b1};
    tbl[17] = '{4'b0010, 32'h0000_A200, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 8'h04, 1'b1};
    tbl[18] = '{4'b0010, 32'h0000_AA00, 4'b0010, 4'b0010, 4'b0000, 1'b1, 2'd1, 8'hA1, 1'b1};
    tbl[19] = '{4'b0000, 32'h0,         4'b0010, 4'b0010, 4'b0000, 1'b1, 2'd1, 8'hA2, 1'b1};
    tbl[20] = '{4'b0000, 32'h0,         4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd1, 8'hAA, 1'b1};
    // Independent multi-port traffic
    tbl[21] = '{4'b1111, 32'h4433_2211, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd1, 8'hAA, 1'b1};
    tbl[22] = '{4'b0001, 32'h0000_0055, 4'b1000, 4'b0111, 4'b0000, 1'b1, 2'd3, 8'h44, 1'b1};
    tbl[23] = '{4'b0000, 32'h0,         4'b0001, 4'b0111, 4'b0000, 1'b1, 2'd0, 8'h11, 1'b1};
    tbl[24] = '{4'b0000, 32'h0,         4'b0001, 4'b0110, 4'b0000, 1'b1, 2'd0, 8'h55, 1'b1};
    tbl[25] = '{4'b0000, 32'h0,         4'b0010, 4'b0100, 4'b0000, 1'b1, 2'd1, 8'h22, 1'b1};
    tbl[26] = '{4'b0000, 32'h0,         4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, 8'h33, 1'b1};
    tbl[27] = '{4'b0000, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd2, 8'h33, 1'b1};

    do_reset("reset");

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].push, tbl[i].data, tbl[i].gnt);
      check($sformatf("vec%0d", i), tbl[i].req, tbl[i].full, tbl[i].valid,
            tbl[i].port, tbl[i].dout, tbl[i].err);
    end

    // Mid-operation reset discards queued entries; grant during reset is ignored
    do_reset("pre_mid");
    step(4'b1000, 32'hD100_0000, 4'b0000);
    step(4'b1000, 32'hD200_0000, 4'b0000);
    check("mid_loaded", 4'b1000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0; push_i = '0; gnt_i = 4'b1000;
    @(posedge clk);
    #1;
    check("mid_rst", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b1; gnt_i = '0;
    @(posedge clk);
    #1;
    check("mid_after", 4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);

    // Multi-bit grant: no pop, error, counts unchanged
    step(4'b0011, 32'h0000_B2B1, 4'b0000);
    check("inv_load", 4'b0011, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    step(4'b0000, 32'h0, 4'b0011);
    check("inv_multi", 4'b0011, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1);
    step(4'b0000, 32'h0, 4'b0010);
    check("inv_pop1", 4'b0001, 4'b0000, 1'b1, 2'd1, 8'hB2, 1'b1);
    step(4'b0000, 32'h0, 4'b0001);
    check("inv_pop0", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'hB1, 1'b1);

    // Grant to an empty port: no pop, error, occupied port untouched
    do_reset("pre_empty");
    step(4'b0001, 32'h0000_00C1, 4'b0000);
    check("emp_load", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    step(4'b0000, 32'h0, 4'b0100);
    check("emp_gnt", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1);
    step(4'b0000, 32'h0, 4'b0001);
    check("emp_pop", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'hC1, 1'b1);

    // Round-robin arbiter loop with two entries preloaded per port
    do_reset("pre_arb");
    step(4'b1111, 32'h3A2A_1A0A, 4'b0000);
    step(4'b1111, 32'h3B2B_1B0B, 4'b0000);
    check("arb_load", 4'b1111, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0);
    begin
      int last = 3;
      int pulses = 0;
      int cnt [4] = '{2, 2, 2, 2};
      for (int cyc = 0; cyc < 20 && pulses < 8; cyc++) begin
        logic [3:0] g;
        logic [3:0] exp_req;
        int idx;
        @(negedge clk);
        g = '0;
        idx = -1;
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (last + k) % 4;
          if (idx < 0 && req_o[c]) idx = c;
        end
        if (idx >= 0) g[idx] = 1'b1;
        push_i = '0; gnt_i = g;
        @(posedge clk);
        #1;
        if (idx >= 0) begin
          int expect_port;
          expect_port = pulses % 4;
          cnt[idx]--;
          for (int p = 0; p < 4; p++) exp_req[p] = (cnt[p] != 0);
          check($sformatf("arb%0d", pulses), exp_req, 4'b0000, 1'b1, 2'(expect_port),
                8'(expect_port * 16 + ((pulses < 4) ? 10 : 11)), 1'b0);
          last = idx;
          pulses++;
        end
      end
      n_vec++;
      if (pulses != 8) begin
        n_fail++;
        $display("FAIL arb_pulses: got %0d pops, want 8", pulses);
      end
      step(4'b0000, 32'h0, 4'b0000);
      check("arb_idle", 4'b0000, 4'b0000, 1'b0, 2'd3, 8'h3B, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_req_queue.md
# rr_req_queue

Per-port request buffering stage that sits directly upstream of the 4-way round-robin arbiter. Holds up to DEPTH pending data words per requester in independent FIFOs. Drives the arbiter's 4-bit request vector from FIFO occupancy, consumes the arbiter's one-hot grant to pop the winning head entry, and presents the popped word with its source port on a registered output.

## Interface

**Parameters**
- DATA_W, 8, width of one request payload word.
- DEPTH, 4, entries per port FIFO; power of two, ≥ 2.

**Ports**
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately when 0.
- push_i  in  4  per-port push strobe; bit p pushes into FIFO p.
- push_data_i  in  4*DATA_W  payload; port p occupies bits [p*DATA_W +: DATA_W].
- full_o  out  4  bit p = FIFO p holds DEPTH entries.
- req_o  out  4  bit p = FIFO p non-empty; connects to arbiter req_i.
- gnt_i  in  4  one-hot grant from arbiter gnt_o.
- out_valid_o  out  1  popped word valid, one cycle per pop.
- out_port_o  out  2  index of port that was popped.
- out_data_o  out  DATA_W  popped payload.
- err_o  out  1  sticky protocol-error flag.

## Operation

- Each port p has:
  - a DEPTH-entry storage array;
  - write pointer, read pointer (log2(DEPTH) bits, natural wrap);
  - occupancy counter (log2(DEPTH)+1 bits, range 0..DEPTH).
- full_o[p] = (count[p] == DEPTH); req_o[p] = (count[p] != 0). Both are combinational decodes of registered counters only, with no path from gnt_i or push_i.
- Push accept: push_i[p] && !full_o[p]. Payload is written at wptr[p] and wptr[p] increments.
- Push while full:
  - rejected and payload dropped;
  - counters unchanged;
  - err_o set.
- full_o is evaluated on the pre-edge count. A push to a full FIFO is rejected even if the same port pops in that cycle.
- Grant accept: gnt_i is one-hot and gnt_i[p] && req_o[p]. Head entry at rptr[p] is popped and rptr[p] increments.
- Invalid grant, with state unchanged and err_o set:
  - gnt_i has more than one bit set;
  - gnt_i names an empty port.
- gnt_i == 0 means no pop and is not an error.
- Same-port push and pop in one cycle (FIFO not full):
  - both take effect and count[p] is unchanged;
  - the popped word is the old head, never the word being pushed;
  - when count was 0, req_o[p] is 0, so no pop can occur and the push lands normally.
- Pushes to different ports, and a pop on one port with pushes on others, are all independent in the same cycle.
- Output register:
  - on a grant accept, out_valid_o←1, out_port_o←p, out_data_o←head[p];
  - otherwise out_valid_o←0, and out_port_o/out_data_o hold their last values.
- err_o is sticky and cleared only by reset.

## Timing

- Reset (reset=0, asynchronous):
  - all counts, pointers, out_valid_o, out_port_o, out_data_o and err_o are 0;
  - therefore req_o=4'b0000 and full_o=4'b0000;
  - storage contents are don't-care.
- Reset mid-operation discards all queued entries at once. No out_valid_o pulse results from a grant in the reset cycle.
- Push to req latency: a push accepted at edge N raises req_o[p] after edge N (visible in cycle N+1).
- Grant to data latency: grant sampled at edge N gives out_valid_o=1 with data in cycle N+1, so latency is 1.
- Throughput is one pop per cycle aggregate and one push per port per cycle.
- The arbiter's combinational gnt_o may depend on req_o. No loop exists because req_o is register-derived.
- Back-to-back grants to the same port drain consecutive entries in FIFO order. req_o[p] falls in the cycle after the last entry pops.

## Test plan

- **Reset values:** hold reset=0 for 2 cycles with random push_i/gnt_i, then release → req_o=0, full_o=0, out_valid_o=0, err_o=0.
- **FIFO order:** with DATA_W=8, push 0x11, 0x22, 0x33 to port 2 on consecutive cycles with gnt_i=0, then gnt_i=4'b0100 for 3 cycles → out_data_o = 0x11, 0x22, 0x33 on 3 consecutive cycles, out_port_o=2, then req_o[2]=0.
- **Full and overflow:** push 5 words to port 0 with DEPTH=4 → full_o[0]=1 after the 4th push, 5th word dropped, err_o=1. Pop 4 → words 1–4 only.
- **Simultaneous push and pop:** port 1 holds 2 entries; push 0xAA with gnt_i=4'b0010 in the same cycle → old head output, count stays 2, 0xAA emerges after the remaining entry.
- **Invalid grant:** gnt_i=4'b0011, then gnt_i selecting an empty port → no pop, out_valid_o=0, counts unchanged, err_o=1.
- **Arbiter loop:** connect to the round-robin arbiter, preload all four ports with 2 entries each → 8 out_valid_o pulses with out_port_o rotating per the arbiter's rotation, all data in per-port FIFO order, then req_o=0.
